// File: rtl/aes_out_serializer_if.sv
// rtl/aes_out_serializer_if.sv - 32-bit result word stream between serializer and host side
interface aes_out_serializer_if;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        dout_last;

    modport master (
        output dout,
        output dout_valid,
        output dout_last,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        input  dout_last,
        output dout_ready
    );
endinterface

// File: rtl/aes_out_serializer.sv
// rtl/aes_out_serializer.sv - tracks aes_128 in-flight blocks, buffers results, emits 4x32-bit words
module aes_out_serializer #(
    parameter int LATENCY    = 21,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_start,
    input  logic [127:0]                  aes_out,
    aes_out_serializer_if.master          dout_bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          clear_ovf,
    output logic                          busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nx;

    logic [LATENCY-1:0] tag;
    logic               capture;

    logic [127:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            fifo_empty;
    logic            fifo_full;
    logic            push;
    logic            drop;

    logic [127:0]    shift;
    logic [1:0]      idx;
    logic            load;
    logic            advance;

    // The tag leaving the top of the shift register marks the cycle its result is on aes_out.
    assign capture    = tag[LATENCY-1];
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_COUNT);

    // A full FIFO still accepts a result when the head leaves on the same edge.
    assign push = capture && (!fifo_full || load);
    assign drop = capture && fifo_full && !load;

    // Tag pipeline: one bit per cycle of core latency, cleared on reset so stale results are ignored.
    if (LATENCY == 1) begin : g_tag_single
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                tag <= '0;
            end else begin
                tag <= in_start;
            end
        end
    end else begin : g_tag_multi
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                tag <= '0;
            end else begin
                tag <= {tag[LATENCY-2:0], in_start};
            end
        end
    end

    // Result storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= aes_out;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally as the depth is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !load) begin
                count <= count + 1'b1;
            end else if (load && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

    // Serializer FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, FIFO pop and word-stream outputs.
    always_comb begin
        state_nx            = state;
        load                = 1'b0;
        advance             = 1'b0;
        dout_bus.dout       = 32'h0;
        dout_bus.dout_valid = 1'b0;
        dout_bus.dout_last  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    load     = 1'b1;
                    state_nx = SEND;
                end
            end
            SEND: begin
                dout_bus.dout       = shift[127:96];
                dout_bus.dout_valid = 1'b1;
                dout_bus.dout_last  = (idx == 2'd3);
                if (dout_bus.dout_ready) begin
                    if (idx != 2'd3) begin
                        advance = 1'b1;
                    end else if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Output shift register: load a whole block, then move the next word into the top slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift <= '0;
            idx   <= 2'd0;
        end else if (load) begin
            shift <= mem[rd_ptr];
            idx   <= 2'd0;
        end else if (advance) begin
            shift <= {shift[95:0], 32'h0};
            idx   <= idx + 2'd1;
        end
    end

    assign fifo_count = count;
    assign busy       = (|tag) || !fifo_empty || (state == SEND);
endmodule

// File: tb/tb_aes_out_serializer.sv
// tb/tb_aes_out_serializer.sv - randomized scenario bench with block-level reference model
module tb_aes_out_serializer;
    localparam int L = 21;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_start;
    logic         clear_ovf;
    logic [127:0] aes_out;
    logic [2:0]   fifo_count;
    logic         overflow;
    logic         busy;
    logic [38:0]  dut_vec;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model: captured blocks waiting, block being sent, pending capture cycles
    logic [127:0] m_q[$];
    logic [127:0] m_cur = '0;
    int           m_idx = 0;
    bit           m_send = 0;
    int           m_pend[$];
    bit           m_ovf = 0;

    always #5 clk = ~clk;

    aes_out_serializer_if bus();

    aes_out_serializer #(.LATENCY(L), .FIFO_DEPTH(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_start   (in_start),
        .aes_out    (aes_out),
        .dout_bus   (bus.master),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .clear_ovf  (clear_ovf),
        .busy       (busy)
    );

    assign dut_vec = {bus.dout, bus.dout_valid, bus.dout_last, fifo_count, overflow, busy};

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] blk_of(int c);
        logic [31:0] c32;
        c32 = 32'(c);
        return {c32 ^ 32'hC0DE0000, c32 ^ 32'h11110000, c32 ^ 32'h22220000, c32 ^ 32'h33330000};
    endfunction

    function automatic logic [38:0] exp_vec();
        logic [127:0] t;
        logic [31:0]  w;
        t = m_cur << (32 * m_idx);
        w = m_send ? t[127:96] : 32'h0;
        return {w, m_send, m_send && (m_idx == 3), 3'(m_q.size()), m_ovf,
                (m_pend.size() > 0) || (m_q.size() > 0) || m_send};
    endfunction

    // block-level behaviour for one clock edge, using the inputs currently driven
    task automatic model_edge();
        bit cap;
        bit pop;
        int occ;
        if (!rst_n) begin
            m_q.delete();
            m_pend.delete();
            m_send = 0;
            m_idx  = 0;
            m_cur  = '0;
            m_ovf  = 0;
            return;
        end
        cap = (m_pend.size() > 0) && (m_pend[0] == cyc);
        occ = m_q.size();
        pop = 0;
        if (!m_send) begin
            pop = (occ > 0);
        end else if (bus.dout_ready) begin
            if (m_idx < 3) m_idx++;
            else if (occ > 0) pop = 1;
            else m_send = 0;
        end
        if (pop) begin
            m_cur  = m_q.pop_front();
            m_idx  = 0;
            m_send = 1;
        end
        if (clear_ovf) m_ovf = 0;
        if (cap) begin
            void'(m_pend.pop_front());
            if (occ < D || pop) m_q.push_back(aes_out);
            else m_ovf = 1;
        end
        if (in_start) m_pend.push_back(cyc + L);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 0;
        in_start = 0;
        clear_ovf = 0;
        bus.dout_ready = 0;
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        in_start = 0;
        clear_ovf = 0;
        bus.dout_ready = 0;
        aes_out = '0;
        tick();
        tick();
        total++;
        if (dut_vec !== 39'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=%h", dut_vec, 39'h0);
        end
        rst_n = 1;
    endtask

    task automatic test_single();
        logic [127:0] v;
        logic [31:0]  got[$];
        logic         lasts[$];
        int           first;
        v = 128'h3925841d02dc09fbdc118597196a0b32;
        first = -1;
        do_reset();
        aes_out = v;
        bus.dout_ready = 1;
        for (int i = 0; i < L + 20; i++) begin
            in_start = (i == 10);
            if (bus.dout_valid && first < 0) first = i;
            if (bus.dout_valid && bus.dout_ready) begin
                got.push_back(bus.dout);
                lasts.push_back(bus.dout_last);
            end
            tick();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL single_cycle%0d got=%h want=%h", i, dut_vec, exp_vec());
            end
        end
        in_start = 0;
        total++;
        if (first != 12 + L) begin
            bad++;
            $display("FAIL single_first_valid got=%0d want=%0d", first, 12 + L);
        end
        total++;
        if (got.size() != 4) begin
            bad++;
            $display("FAIL single_word_count got=%0d want=4", got.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (got[k] !== v[127 - 32 * k -: 32] || lasts[k] !== (k == 3)) begin
                    bad++;
                    $display("FAIL single_word%0d got=%h/%b want=%h/%b", k, got[k], lasts[k],
                             v[127 - 32 * k -: 32], (k == 3));
                end
            end
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL single_busy_after got=%b want=0", busy);
        end
    endtask

    task automatic test_backpressure();
        bit           pat[7];
        logic [127:0] v;
        logic [31:0]  got[$];
        logic [33:0]  prev;
        bit           hold;
        pat = '{1, 0, 0, 1, 0, 1, 1};
        v = rnd128();
        hold = 0;
        prev = '0;
        do_reset();
        aes_out = v;
        for (int i = 0; i < L + 30; i++) begin
            in_start = (i == 2);
            bus.dout_ready = (i >= L + 4) ? pat[(i - L - 4) % 7] : 1'b0;
            if (hold) begin
                total++;
                if ({bus.dout, bus.dout_valid, bus.dout_last} !== prev) begin
                    bad++;
                    $display("FAIL bp_hold_cycle%0d got=%h want=%h", i,
                             {bus.dout, bus.dout_valid, bus.dout_last}, prev);
                end
            end
            hold = bus.dout_valid && !bus.dout_ready;
            prev = {bus.dout, bus.dout_valid, bus.dout_last};
            if (bus.dout_valid && bus.dout_ready) got.push_back(bus.dout);
            tick();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL bp_cycle%0d got=%h want=%h", i, dut_vec, exp_vec());
            end
        end
        in_start = 0;
        total++;
        if (got.size() != 4) begin
            bad++;
            $display("FAIL bp_transfer_count got=%0d want=4", got.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (got[k] !== v[127 - 32 * k -: 32]) begin
                    bad++;
                    $display("FAIL bp_word%0d got=%h want=%h", k, got[k], v[127 - 32 * k -: 32]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        int           s0;
        logic [31:0]  got[$];
        logic [127:0] b;
        do_reset();
        s0 = cyc;
        for (int i = 0; i < L + 9; i++) begin
            in_start = (i < 6);
            aes_out = blk_of(cyc);
            bus.dout_ready = 0;
            tick();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL ovf_fill_cycle%0d got=%h want=%h", i, dut_vec, exp_vec());
            end
        end
        in_start = 0;
        total++;
        if (fifo_count !== 3'd4 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_saturate got=%0d/%b want=4/1", fifo_count, overflow);
        end
        bus.dout_ready = 1;
        for (int i = 0; i < 30; i++) begin
            aes_out = blk_of(cyc);
            if (bus.dout_valid) got.push_back(bus.dout);
            tick();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL ovf_drain_cycle%0d got=%h want=%h", i, dut_vec, exp_vec());
            end
        end
        total++;
        if (got.size() != 20) begin
            bad++;
            $display("FAIL ovf_drain_count got=%0d want=20", got.size());
        end else begin
            for (int j = 0; j < 20; j++) begin
                b = blk_of(s0 + L + j / 4);
                total++;
                if (got[j] !== b[127 - 32 * (j % 4) -: 32]) begin
                    bad++;
                    $display("FAIL ovf_drain_word%0d got=%h want=%h", j, got[j],
                             b[127 - 32 * (j % 4) -: 32]);
                end
            end
        end
        clear_ovf = 1;
        tick();
        clear_ovf = 0;
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear got=%b want=0", overflow);
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int i = 0; i < L + 26; i++) begin
            in_start = (i < 5) || (i == 20);
            bus.dout_ready = (i >= L + 17);
            aes_out = rnd128();
            if (i == L + 20) begin
                total++;
                if ({bus.dout_valid, bus.dout_last, fifo_count} !== {2'b11, 3'd4}) begin
                    bad++;
                    $display("FAIL fullpop_setup got=%b%b/%0d want=11/4", bus.dout_valid,
                             bus.dout_last, fifo_count);
                end
            end
            tick();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL fullpop_cycle%0d got=%h want=%h", i, dut_vec, exp_vec());
            end
            if (i == L + 20) begin
                total++;
                if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
                    bad++;
                    $display("FAIL fullpop_accept got=%0d/%b want=4/0", fifo_count, overflow);
                end
            end
        end
        in_start = 0;
    endtask

    task automatic test_back_to_back();
        int          run;
        bit          done;
        logic [11:0] lasts;
        run = 0;
        done = 0;
        lasts = '0;
        do_reset();
        for (int i = 0; i < L + 26; i++) begin
            in_start = (i < 3);
            bus.dout_ready = (i >= L + 6);
            aes_out = rnd128();
            if (i >= L + 6 && !done) begin
                if (bus.dout_valid) begin
                    run++;
                    lasts = {lasts[10:0], bus.dout_last};
                end else if (run > 0) begin
                    done = 1;
                end
            end
            tick();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL b2b_cycle%0d got=%h want=%h", i, dut_vec, exp_vec());
            end
        end
        in_start = 0;
        total++;
        if (run != 12 || lasts !== 12'h111) begin
            bad++;
            $display("FAIL b2b_run got=%0d/%h want=12/111", run, lasts);
        end
    endtask

    task automatic test_reset_mid();
        int vcount;
        int xcount;
        vcount = 0;
        xcount = 0;
        do_reset();
        bus.dout_ready = 1;
        for (int i = 0; i <= L + 4; i++) begin
            in_start = (i < 3) || (i == L);
            rst_n = (i != L + 4);
            aes_out = rnd128();
            tick();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL rstmid_cycle%0d got=%h want=%h", i, dut_vec, exp_vec());
            end
        end
        rst_n = 1;
        in_start = 0;
        total++;
        if (dut_vec !== 39'h0) begin
            bad++;
            $display("FAIL rstmid_cleared got=%h want=%h", dut_vec, 39'h0);
        end
        for (int i = 0; i < 2 * L; i++) begin
            aes_out = rnd128();
            if (bus.dout_valid) vcount++;
            tick();
        end
        total++;
        if (vcount != 0) begin
            bad++;
            $display("FAIL rstmid_stale_output got=%0d want=0", vcount);
        end
        for (int i = 0; i < L + 10; i++) begin
            in_start = (i == 0);
            aes_out = rnd128();
            if (bus.dout_valid && bus.dout_ready) xcount++;
            tick();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL rstmid_after_cycle%0d got=%h want=%h", i, dut_vec, exp_vec());
            end
        end
        in_start = 0;
        total++;
        if (xcount != 4) begin
            bad++;
            $display("FAIL rstmid_new_block got=%0d want=4", xcount);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            in_start = ($urandom_range(0, 4) == 0);
            bus.dout_ready = ($urandom_range(0, 3) != 0);
            clear_ovf = ($urandom_range(0, 49) == 0);
            aes_out = rnd128();
            tick();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL random_cycle%0d got=%h want=%h", i, dut_vec, exp_vec());
            end
        end
        rst_n = 1;
        in_start = 0;
        clear_ovf = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_full_pop();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/aes_out_serializer.md
Name: aes_out_serializer

Overview:
- Downstream stage of the aes_128 pipeline. Tracks in-flight blocks with a valid shift register matched to the core's fixed latency, and captures each finished 128-bit result into a small FIFO.
- Drains captured results as four 32-bit words over a valid/ready stream to the host/bus side.
- Lets the free-running AES pipeline run without stalls. Backpressure is absorbed by the FIFO; overflow is flagged, never stalls the core.

Parameters:
- LATENCY, 21, cycles from in_start to the matching result on aes_out; must be >= 1.
- FIFO_DEPTH, 4, number of 128-bit result entries; power of two, >= 2.

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- in_start  input  1  high in the cycle a new key/state is presented to aes_128
- aes_out  input  128  aes_128 output bus, sampled only when the tracked tag emerges
- dout  output  32  serialized result word
- dout_valid  output  1  dout holds a valid word
- dout_ready  input  1  consumer accepts the word; transfer occurs when dout_valid & dout_ready
- dout_last  output  1  high with the 4th (final) word of a block
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- overflow  output  1  sticky: a result was dropped because the FIFO was full
- clear_ovf  input  1  synchronous clear of overflow
- busy  output  1  any tag in flight, FIFO non-empty, or serializer in SEND

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - tag shift register, FIFO pointers and count, FSM, word index and overflow all cleared.
  - dout=0, dout_valid=0, dout_last=0, fifo_count=0, busy=0.
  - In-flight tags are discarded. A result emerging after reset deasserts is not captured.
- Tag pipeline: LATENCY-bit shift register; bit 0 loads in_start each cycle.
- Capture:
  - When the last tag bit is 1, aes_out is sampled at that edge.
  - For in_start high in cycle T, the capture edge is at the end of cycle T+LATENCY.
- FIFO push:
  - Push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the result is dropped, overflow is set, and the count is unchanged.
  - If clear_ovf and a drop happen in the same cycle, set wins.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, SEND.
  - IDLE: if the FIFO is non-empty, pop the head into a 128-bit shift register, word index=0, go to SEND.
  - SEND:
    - dout_valid=1; dout = shift[127:96], most significant word first.
    - dout_last=1 when word index=3.
    - On a transfer with index<3: shift left 32 and increment the index.
    - On a transfer with index=3 and FIFO non-empty: pop the next entry the same edge and stay in SEND. Back-to-back blocks have no bubble.
    - On a transfer with index=3 and FIFO empty: go to IDLE; dout_valid drops the next cycle.
  - While dout_valid=1 and dout_ready=0, dout and dout_last hold stable.
- Latency: the first word is valid in cycle T+LATENCY+2 (one cycle in FIFO, one cycle in IDLE load).
- Simultaneous push and pop: occupancy is unchanged. A push into an empty FIFO cannot be popped in the same cycle; there is no bypass.
- Throughput:
  - Sustained output is 1 block per 4 cycles when dout_ready=1.
  - in_start faster than 1 per 4 cycles eventually overflows.
- dout_ready has no effect in IDLE.
- A dropped block never appears on dout, and its neighbours are unaffected.

Test Plan:
- Single block:
  - Stimulus: in_start once at cycle 10; aes_out=128'h3925841d02dc09fbdc118597196a0b32 during cycle 10+LATENCY; dout_ready=1.
  - Response: dout_valid first high at cycle 12+LATENCY; words 3925841d, 02dc09fb, dc118597, 196a0b32; dout_last only on the 4th word; busy low afterwards.
- Backpressure:
  - Stimulus: same block; dout_ready toggles 1,0,0,1,0,1,1.
  - Response: each word held stable while not ready; exactly 4 transfers in order; no duplicates.
- Overflow:
  - Stimulus: 6 in_start pulses spaced 1 cycle apart with distinct aes_out values; dout_ready=0 until all are captured.
  - Response: fifo_count saturates at 4 (serializer also holds one block); overflow=1 after the 6th; the 5 stored blocks drain in order; clear_ovf then clears overflow.
- Full plus pop:
  - Stimulus: FIFO full, with a capture in the same cycle as a last-word transfer and pop.
  - Response: push accepted; fifo_count stays 4; overflow stays 0.
- Back-to-back:
  - Stimulus: 3 blocks captured; dout_ready=1.
  - Response: 12 consecutive valid cycles with no bubble; dout_last every 4th word.
- Reset mid-operation:
  - Stimulus: rst_n=0 for 1 cycle during word 2 of a block, with 2 FIFO entries and tags in flight.
  - Response: next cycle all outputs are 0 and fifo_count=0; in-flight results are never output; a new in_start after reset works normally.
